chess_move_entry: RTL and testbench

Keyboard move-entry stage between the PS/2 ASCII decoder and the chess state machine. Assembles typed algebraic coordinates (e.g. "e2e4") into from/to square indices, validates each character, supports edit keys, and offers the completed move under a valid/ack handshake. It also exports entry progress for the HEX/VGA debug display.

---
 rtl/chess_move_entry_if.sv | 42 ++++
 rtl/chess_move_entry.sv | 181 ++++++++++++++++++
 tb/tb_chess_move_entry.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chess_move_entry_if.sv
// chess_move_entry_if: character/move bus around the keyboard move-entry stage.
//   ascii_char  character from the PS/2 decoder
//   ready       decoder character-ready level (new character on rising edge)
//   move_ack    chess state machine has consumed the offered move
//   from_sq     {rank-1, file} of the source square, file a=0
//   to_sq       {rank-1, file} of the destination square
//   move_valid  move offered, held until acknowledged
//   entry_cnt   characters accepted so far, 0..4
//   entry_err   one-cycle pulse per rejected character or illegal confirm
// master: decoder / chess state machine side. slave: the move-entry block.
interface chess_move_entry_if;
  logic [7:0] ascii_char;
  logic       ready;
  logic       move_ack;
  logic [5:0] from_sq;
  logic [5:0] to_sq;
  logic       move_valid;
  logic [2:0] entry_cnt;
  logic       entry_err;

  modport master (
    output ascii_char,
    output ready,
    output move_ack,
    input  from_sq,
    input  to_sq,
    input  move_valid,
    input  entry_cnt,
    input  entry_err
  );

  modport slave (
    input  ascii_char,
    input  ready,
    input  move_ack,
    output from_sq,
    output to_sq,
    output move_valid,
    output entry_cnt,
    output entry_err
  );
endinterface

// File: rtl/chess_move_entry.sv
// chess_move_entry: assembles typed algebraic coordinates ("e2e4") into from/to square
// indices, validates each character, handles backspace/escape, and offers the finished
// move under a valid/ack handshake.
//   CLOCK_27  system clock (decoder clock domain)
//   RESET     synchronous, active-high reset
//   ENTER     raw asynchronous push-button level, confirms the move
//   bus       chess_move_entry_if.slave: ascii_char/ready/move_ack in,
//             from_sq/to_sq/move_valid/entry_cnt/entry_err out (all registered)
module chess_move_entry #(
  parameter logic [7:0] BKSP_CODE      = 8'h08,
  parameter logic [7:0] ESC_CODE       = 8'h1B,
  parameter logic [7:0] KBD_ENTER_CODE = 8'h0D
) (
  input  logic                 CLOCK_27,
  input  logic                 RESET,
  input  logic                 ENTER,
  chess_move_entry_if.slave    bus
);

  typedef enum logic [2:0] {
    StF0,
    StR0,
    StF1,
    StR1,
    StDone,
    StOffer
  } state_e;

  state_e state_q;
  logic   ready_q;
  logic   enter_s1_q;
  logic   enter_s2_q;
  logic   enter_s3_q;

  logic       chr_stb;
  logic       btn_stb;
  logic       kbd_confirm;
  logic       confirm;
  logic       is_file;
  logic       is_rank;
  logic       is_bksp;
  logic       is_esc;
  logic [2:0] file_val;
  logic [2:0] rank_val;

  always_comb begin
    chr_stb     = bus.ready & ~ready_q;
    btn_stb     = enter_s2_q & ~enter_s3_q;
    kbd_confirm = chr_stb && (bus.ascii_char == KBD_ENTER_CODE);
    confirm     = btn_stb | kbd_confirm;

    is_file = ((bus.ascii_char >= 8'h61) && (bus.ascii_char <= 8'h68)) ||
              ((bus.ascii_char >= 8'h41) && (bus.ascii_char <= 8'h48));
    is_rank = (bus.ascii_char >= 8'h31) && (bus.ascii_char <= 8'h38);
    is_bksp = (bus.ascii_char == BKSP_CODE);
    is_esc  = (bus.ascii_char == ESC_CODE);

    // 'a'/'A'/'1' all end in 3'b001, so the low three bits minus one give the index.
    file_val = bus.ascii_char[2:0] - 3'd1;
    rank_val = bus.ascii_char[2:0] - 3'd1;
  end

  always_ff @(posedge CLOCK_27) begin
    if (RESET) begin
      state_q        <= StF0;
      ready_q        <= 1'b0;
      enter_s1_q     <= 1'b0;
      enter_s2_q     <= 1'b0;
      enter_s3_q     <= 1'b0;
      bus.from_sq    <= 6'd0;
      bus.to_sq      <= 6'd0;
      bus.move_valid <= 1'b0;
      bus.entry_cnt  <= 3'd0;
      bus.entry_err  <= 1'b0;
    end else begin
      ready_q       <= bus.ready;
      enter_s1_q    <= ENTER;
      enter_s2_q    <= enter_s1_q;
      enter_s3_q    <= enter_s2_q;
      bus.entry_err <= 1'b0;

      if (state_q == StOffer) begin
        // Squares are frozen; only the ack matters, and any same-cycle key is dropped.
        if (bus.move_ack) begin
          state_q        <= StF0;
          bus.move_valid <= 1'b0;
          bus.from_sq    <= 6'd0;
          bus.to_sq      <= 6'd0;
          bus.entry_cnt  <= 3'd0;
        end
      end else if (confirm) begin
        // Takes precedence over a simultaneous ordinary key, which is discarded.
        if (state_q == StDone && bus.from_sq != bus.to_sq) begin
          state_q        <= StOffer;
          bus.move_valid <= 1'b1;
        end else if (state_q == StDone) begin
          state_q       <= StF0;
          bus.from_sq   <= 6'd0;
          bus.to_sq     <= 6'd0;
          bus.entry_cnt <= 3'd0;
          bus.entry_err <= 1'b1;
        end else begin
          bus.entry_err <= 1'b1;
        end
      end else if (chr_stb) begin
        if (is_esc) begin
          state_q       <= StF0;
          bus.from_sq   <= 6'd0;
          bus.to_sq     <= 6'd0;
          bus.entry_cnt <= 3'd0;
        end else if (is_bksp) begin
          case (state_q)
            StR0: begin
              state_q          <= StF0;
              bus.from_sq[2:0] <= 3'd0;
              bus.entry_cnt    <= 3'd0;
            end
            StF1: begin
              state_q          <= StR0;
              bus.from_sq[5:3] <= 3'd0;
              bus.entry_cnt    <= 3'd1;
            end
            StR1: begin
              state_q        <= StF1;
              bus.to_sq[2:0] <= 3'd0;
              bus.entry_cnt  <= 3'd2;
            end
            StDone: begin
              state_q        <= StR1;
              bus.to_sq[5:3] <= 3'd0;
              bus.entry_cnt  <= 3'd3;
            end
            default: ;
          endcase
        end else begin
          case (state_q)
            StF0: begin
              if (is_file) begin
                state_q          <= StR0;
                bus.from_sq[2:0] <= file_val;
                bus.entry_cnt    <= 3'd1;
              end else begin
                bus.entry_err <= 1'b1;
              end
            end
            StR0: begin
              if (is_rank) begin
                state_q          <= StF1;
                bus.from_sq[5:3] <= rank_val;
                bus.entry_cnt    <= 3'd2;
              end else begin
                bus.entry_err <= 1'b1;
              end
            end
            StF1: begin
              if (is_file) begin
                state_q        <= StR1;
                bus.to_sq[2:0] <= file_val;
                bus.entry_cnt  <= 3'd3;
              end else begin
                bus.entry_err <= 1'b1;
              end
            end
            StR1: begin
              if (is_rank) begin
                state_q        <= StDone;
                bus.to_sq[5:3] <= rank_val;
                bus.entry_cnt  <= 3'd4;
              end else begin
                bus.entry_err <= 1'b1;
              end
            end
            // Entry complete: only edit keys or confirm are meaningful.
            default: bus.entry_err <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_chess_move_entry.sv
// tb_chess_move_entry: directed test-plan steps followed by random keystrokes, button
// presses and acks, every cycle compared with a text-buffer model of the move entry.
module tb_chess_move_entry;

  localparam logic [7:0] Bksp = 8'h08;
  localparam logic [7:0] Esc  = 8'h1B;
  localparam logic [7:0] Cr   = 8'h0D;

  logic clk = 1'b0;
  logic rst;
  logic enter;

  chess_move_entry_if bus ();

  chess_move_entry #(
    .BKSP_CODE      (Bksp),
    .ESC_CODE       (Esc),
    .KBD_ENTER_CODE (Cr)
  ) dut (
    .CLOCK_27 (clk),
    .RESET    (rst),
    .ENTER    (enter),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the accepted characters as typed, plus whether a move is on offer.
  logic [7:0] mbuf[$];
  bit         moffer;
  bit         merr;
  bit         prev_rdy;
  bit         h1, h2, h3;  // ENTER pin as sampled at the last three edges

  function automatic bit is_file(logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h68) || (c >= 8'h41 && c <= 8'h48);
  endfunction

  function automatic bit is_rank(logic [7:0] c);
    return c >= 8'h31 && c <= 8'h38;
  endfunction

  // Square from buffer positions idx (file) and idx+1 (rank); missing parts read as 0.
  function automatic logic [5:0] sq(int idx);
    logic [5:0] s = 6'd0;
    if (mbuf.size() > idx)
      s[2:0] = (mbuf[idx] >= 8'h61) ? 3'(mbuf[idx] - 8'h61) : 3'(mbuf[idx] - 8'h41);
    if (mbuf.size() > idx + 1) s[5:3] = 3'(mbuf[idx+1] - 8'h31);
    return s;
  endfunction

  function automatic void m_confirm();
    if (mbuf.size() == 4 && sq(0) != sq(2)) begin
      moffer = 1'b1;
    end else begin
      merr = 1'b1;
      if (mbuf.size() == 4) mbuf.delete();
    end
  endfunction

  function automatic void m_char(logic [7:0] c);
    bit want_file;
    want_file = (mbuf.size() % 2) == 0;
    if (c == Cr) m_confirm();
    else if (c == Esc) mbuf.delete();
    else if (c == Bksp) begin
      if (mbuf.size() > 0) void'(mbuf.pop_back());
    end else if (mbuf.size() < 4 && (want_file ? is_file(c) : is_rank(c))) mbuf.push_back(c);
    else merr = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".from_sq"}, 8'(bus.from_sq), 8'(sq(0)));
    chk({tag, ".to_sq"}, 8'(bus.to_sq), 8'(sq(2)));
    chk({tag, ".move_valid"}, 8'(bus.move_valid), 8'(moffer));
    chk({tag, ".entry_cnt"}, 8'(bus.entry_cnt), moffer ? 8'd4 : 8'(mbuf.size()));
    chk({tag, ".entry_err"}, 8'(bus.entry_err), 8'(merr));
  endtask

  // One clock: inputs are already set; update the model at the edge, check at negedge.
  task automatic tick(input string tag);
    bit chr, bev;
    @(posedge clk);
    chr  = bus.ready & ~prev_rdy;
    bev  = h2 & ~h3;  // button acts on the third edge after the pin rises
    merr = 1'b0;
    if (rst) begin
      mbuf.delete();
      moffer   = 1'b0;
      prev_rdy = 1'b0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    end else begin
      if (moffer) begin
        if (bus.move_ack) begin
          mbuf.delete();
          moffer = 1'b0;
        end
      end else if (bev) m_confirm();
      else if (chr) m_char(bus.ascii_char);
      prev_rdy = bus.ready;
      h3 = h2; h2 = h1; h1 = enter;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic type_c(input logic [7:0] c);
    bus.ascii_char = c;
    bus.ready      = 1'b1;
    tick("key");
    bus.ready = 1'b0;
    tick("gap");
    tick("gap");
  endtask

  task automatic type_s(input string s);
    for (int i = 0; i < s.len(); i++) type_c(8'(s[i]));
  endtask

  task automatic press(input int n);
    enter = 1'b1;
    repeat (n) tick("btn");
    enter = 1'b0;
    repeat (3) tick("btn_rel");
  endtask

  task automatic ack();
    bus.move_ack = 1'b1;
    tick("ack");
    bus.move_ack = 1'b0;
    tick("ack_gap");
  endtask

  logic [7:0] pool[32];
  string      pool_s = "abcdefghABCDEFGH12345678i90z ";

  initial begin
    rst            = 1'b1;
    enter          = 1'b0;
    bus.ascii_char = 8'h00;
    bus.ready      = 1'b0;
    bus.move_ack   = 1'b0;
    for (int i = 0; i < 29; i++) pool[i] = 8'(pool_s[i]);
    pool[29] = Bksp;
    pool[30] = Esc;
    pool[31] = Cr;

    tick("reset");
    rst = 1'b0;
    tick("post_reset");

    // e2e4 + button held 10 cycles.
    type_s("e2e4");
    chk("tp1.cnt4", 8'(bus.entry_cnt), 8'd4);
    enter = 1'b1;
    tick("btn1");
    tick("btn2");
    chk("tp1.no_valid_yet", 8'(bus.move_valid), 8'd0);
    tick("btn3");
    chk("tp1.valid_at_3", 8'(bus.move_valid), 8'd1);
    repeat (7) tick("btn_hold");
    enter = 1'b0;
    repeat (3) tick("btn_rel");
    chk("tp1.from12", 8'(bus.from_sq), 8'd12);
    chk("tp1.to28", 8'(bus.to_sq), 8'd28);

    // Offer is frozen while unacknowledged.
    repeat (20) tick("wait_ack");
    type_c("a");
    chk("tp2.still_valid", 8'(bus.move_valid), 8'd1);
    ack();
    chk("tp2.cnt0", 8'(bus.entry_cnt), 8'd0);

    // Uppercase file, bad rank, then good rank.
    type_c("E");
    chk("tp3.from4", 8'(bus.from_sq), 8'd4);
    bus.ascii_char = "9";
    bus.ready      = 1'b1;
    tick("key9");
    chk("tp3.err9", 8'(bus.entry_err), 8'd1);
    bus.ready = 1'b0;
    tick("gap");
    type_c("7");
    chk("tp3.from52", 8'(bus.from_sq), 8'd52);
    type_c(Esc);

    // Backspace editing and keyboard confirm.
    type_s("g1");
    type_c(Bksp);
    type_c(Bksp);
    type_s("b1c3");
    type_c(Cr);
    chk("tp4.from1", 8'(bus.from_sq), 8'd1);
    chk("tp4.to18", 8'(bus.to_sq), 8'd18);
    chk("tp4.valid", 8'(bus.move_valid), 8'd1);
    ack();

    // Null move and premature confirm.
    type_s("d4d4");
    bus.ascii_char = Cr;
    bus.ready      = 1'b1;
    tick("null_confirm");
    chk("tp5.null_err", 8'(bus.entry_err), 8'd1);
    bus.ready = 1'b0;
    tick("gap");
    type_s("h8");
    type_c(Cr);
    chk("tp5.cnt2", 8'(bus.entry_cnt), 8'd2);
    type_c(Esc);

    // ESC clears, reset kills an offer.
    type_s("e2e");
    type_c(Esc);
    chk("tp6.esc_cnt0", 8'(bus.entry_cnt), 8'd0);
    type_s("a1b2");
    type_c(Cr);
    rst = 1'b1;
    tick("mid_offer_reset");
    rst = 1'b0;
    chk("tp6.reset_valid0", 8'(bus.move_valid), 8'd0);
    repeat (5) tick("post_reset");

    // ready held high: one strobe only, even though the character changes.
    bus.ascii_char = "c";
    bus.ready      = 1'b1;
    tick("hold");
    bus.ascii_char = "3";
    repeat (49) tick("hold");
    bus.ready = 1'b0;
    tick("hold_rel");
    chk("tp6.hold_cnt1", 8'(bus.entry_cnt), 8'd1);
    type_c(Esc);

    // Button strobe and ordinary key in the same cycle: button wins.
    type_s("c3c4");
    enter = 1'b1;
    tick("btn1");
    tick("btn2");
    bus.ascii_char = "a";
    bus.ready      = 1'b1;
    tick("btn_and_key");
    chk("same_cycle.valid", 8'(bus.move_valid), 8'd1);
    chk("same_cycle.err", 8'(bus.entry_err), 8'd0);
    bus.ready = 1'b0;
    enter     = 1'b0;
    repeat (3) tick("gap");

    // Ack and key together: key dropped.
    bus.move_ack   = 1'b1;
    bus.ascii_char = "e";
    bus.ready      = 1'b1;
    tick("ack_and_key");
    bus.move_ack = 1'b0;
    bus.ready    = 1'b0;
    tick("gap");
    chk("ack_key.cnt0", 8'(bus.entry_cnt), 8'd0);

    // Random mix against the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) type_c(pool[$urandom_range(0, 31)]);
      else if (r < 80) press($urandom_range(1, 4));
      else if (r < 92) ack();
      else tick("idle");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
